// File: rtl/accum_write_sequencer_if.sv
// Handshake/config/write bundle between the accumulator write sequencer and its
// neighbours: systolic-array valid in, skewed per-column accumulator writes out.
interface accum_write_sequencer_if #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_K_PASSES = 8
);
  localparam int ADDR_W = $clog2(MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS));
  localparam int MW = (MAX_OUT_ROWS / SYS_ARR_ROWS > 1) ? $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS) : 1;
  localparam int NW = (MAX_OUT_COLS / SYS_ARR_COLS > 1) ? $clog2(MAX_OUT_COLS / SYS_ARR_COLS) : 1;
  localparam int KW = (MAX_K_PASSES > 1) ? $clog2(MAX_K_PASSES) : 1;

  logic                             start;
  logic [MW-1:0]                    cfg_m_last;
  logic [NW-1:0]                    cfg_n_last;
  logic [KW-1:0]                    cfg_k_last;
  logic                             sys_out_valid;
  logic                             busy;
  logic                             done;
  logic [SYS_ARR_COLS-1:0]          wr_en;
  logic [SYS_ARR_COLS*ADDR_W-1:0]   wr_addr;
  logic [SYS_ARR_COLS-1:0]          accum_en;

  modport master (
    output start, cfg_m_last, cfg_n_last, cfg_k_last, sys_out_valid,
    input  busy, done, wr_en, wr_addr, accum_en
  );

  modport slave (
    input  start, cfg_m_last, cfg_n_last, cfg_k_last, sys_out_valid,
    output busy, done, wr_en, wr_addr, accum_en
  );
endinterface

// File: rtl/accum_write_sequencer.sv
// Walks sub_row/K-pass/sub-matrix indices over systolic output beats and issues
// accumulator writes skewed one cycle per accumulator column.
module accum_write_sequencer #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_K_PASSES = 8
) (
  input logic                    clk,
  input logic                    reset,
  accum_write_sequencer_if.slave bus
);
  localparam int ADDR_W = $clog2(MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS));
  localparam int MW = (MAX_OUT_ROWS / SYS_ARR_ROWS > 1) ? $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS) : 1;
  localparam int NW = (MAX_OUT_COLS / SYS_ARR_COLS > 1) ? $clog2(MAX_OUT_COLS / SYS_ARR_COLS) : 1;
  localparam int KW = (MAX_K_PASSES > 1) ? $clog2(MAX_K_PASSES) : 1;
  localparam int RW = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Only the last column still holding a write means the final beat is issuing.
  localparam logic [SYS_ARR_COLS-1:0] LAST_ONLY = SYS_ARR_COLS'(1) << (SYS_ARR_COLS - 1);

  logic [1:0]    state_q, state_d;
  logic [MW-1:0] cfg_m_q;
  logic [NW-1:0] cfg_n_q;
  logic [KW-1:0] cfg_k_q;
  logic [RW-1:0] sub_row_q, sub_row_d;
  logic [KW-1:0] k_q, k_d;
  logic [MW-1:0] m_q, m_d;
  logic [NW-1:0] n_q, n_d;

  logic [SYS_ARR_COLS-1:0]             wr_en_q;
  logic [SYS_ARR_COLS-1:0][ADDR_W-1:0] addr_q;
  logic [SYS_ARR_COLS-1:0]             acc_q;

  logic              accept, beat;
  logic [ADDR_W-1:0] beat_addr;

  assign accept    = (state_q == S_IDLE) && bus.start;
  assign beat      = (state_q == S_RUN) && bus.sys_out_valid;
  assign beat_addr = ADDR_W'(32'(n_q) * MAX_OUT_ROWS + 32'(m_q) * SYS_ARR_ROWS + 32'(sub_row_q));

  always_comb begin
    state_d   = state_q;
    sub_row_d = sub_row_q;
    k_d       = k_q;
    m_d       = m_q;
    n_d       = n_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d   = S_RUN;
        sub_row_d = '0;
        k_d       = '0;
        m_d       = '0;
        n_d       = '0;
      end
      S_RUN: if (beat) begin
        if (sub_row_q == RW'(SYS_ARR_ROWS - 1)) begin
          sub_row_d = '0;
          if (k_q == cfg_k_q) begin
            k_d = '0;
            if (m_q == cfg_m_q) begin
              m_d = '0;
              if (n_q == cfg_n_q) state_d = S_DRAIN;
              else                n_d = n_q + 1'b1;
            end else m_d = m_q + 1'b1;
          end else k_d = k_q + 1'b1;
        end else sub_row_d = sub_row_q + 1'b1;
      end
      S_DRAIN: if (wr_en_q == LAST_ONLY) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sub_row_q <= '0;
      k_q       <= '0;
      m_q       <= '0;
      n_q       <= '0;
      cfg_m_q   <= '0;
      cfg_n_q   <= '0;
      cfg_k_q   <= '0;
    end else begin
      state_q   <= state_d;
      sub_row_q <= sub_row_d;
      k_q       <= k_d;
      m_q       <= m_d;
      n_q       <= n_d;
      if (accept) begin
        cfg_m_q <= bus.cfg_m_last;
        cfg_n_q <= bus.cfg_n_last;
        cfg_k_q <= bus.cfg_k_last;
      end
    end
  end

  // Column 0 registers the beat; every later column copies its left neighbour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q[0] <= 1'b0;
      addr_q[0]  <= '0;
      acc_q[0]   <= 1'b0;
    end else begin
      wr_en_q[0] <= beat;
      addr_q[0]  <= beat_addr;
      acc_q[0]   <= (k_q != '0);
    end
  end

  for (genvar c = 1; c < SYS_ARR_COLS; c++) begin : g_skew
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_en_q[c] <= 1'b0;
        addr_q[c]  <= '0;
        acc_q[c]   <= 1'b0;
      end else begin
        wr_en_q[c] <= wr_en_q[c-1];
        addr_q[c]  <= addr_q[c-1];
        acc_q[c]   <= acc_q[c-1];
      end
    end
  end

  assign bus.busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = addr_q;
  assign bus.accum_en = acc_q;
endmodule

// File: doc/accum_write_sequencer.md
Name: accum_write_sequencer

Overview:
- Sequences accumulator-table writes for a divide-and-conquer matmul.
- Counts systolic-array output beats and walks sub_row, K-pass, sub-matrix row and sub-matrix column.
- Forms the accumulator row address and skews write enable, address and accumulate flag one cycle per accumulator column.
- Sits between the systolic-array output valid and the per-column accumulator tables.

Parameters:
MAX_OUT_ROWS, 128, max output matrix rows
MAX_OUT_COLS, 128, max output matrix cols
SYS_ARR_ROWS, 16, systolic array rows (beats per sub-matrix)
SYS_ARR_COLS, 16, systolic array cols = accumulator columns
MAX_K_PASSES, 8, max partial-product passes per output tile
Derived (localparam):
- ADDR_W = clog2(MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS)) (10 at defaults)
- MW = clog2(MAX_OUT_ROWS/SYS_ARR_ROWS)
- NW = clog2(MAX_OUT_COLS/SYS_ARR_COLS)
- KW = clog2(MAX_K_PASSES)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle job start; sampled only in IDLE
cfg_m_last  in  MW  sub-matrix rows minus 1
cfg_n_last  in  NW  sub-matrix cols minus 1
cfg_k_last  in  KW  K passes minus 1
sys_out_valid  in  1  systolic array presents one output row this cycle
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
wr_en  out  SYS_ARR_COLS  per-column write enable
wr_addr  out  SYS_ARR_COLS*ADDR_W  per-column address; column c at [c*ADDR_W +: ADDR_W]
accum_en  out  SYS_ARR_COLS  per-column 1 = add to stored value, 0 = overwrite

Behaviour:
- Reset (async, any state): state=IDLE; all counters, busy, done, wr_en, wr_addr, accum_en = 0.
- IDLE:
  - start=1 latches cfg_* and clears counters (sub_row, k, m, n); go to RUN.
  - sys_out_valid is ignored.
- RUN: each cycle with sys_out_valid=1 is a beat.
  - A cycle with sys_out_valid=0 holds all counters and inserts no write (bubble propagates down the skew).
  - Beat address = n*MAX_OUT_ROWS + m*SYS_ARR_ROWS + sub_row, truncated to ADDR_W.
  - Beat accumulate flag = (k != 0).
  - Counter order, fastest first: sub_row wraps at SYS_ARR_ROWS-1 → k wraps at cfg_k_last → m wraps at cfg_m_last → n.
  - Beat at sub_row=SYS_ARR_ROWS-1, k=cfg_k_last, m=cfg_m_last, n=cfg_n_last is the final beat → DRAIN.
- Skew pipeline, beat at cycle t:
  - wr_en[0]=1 with its addr/accum on cycle t+1 (registered).
  - Column c receives the same values on cycle t+1+c.
  - Non-beat cycles shift wr_en=0; addr/accum contents are don't-care when wr_en=0.
- DRAIN: ignores sys_out_valid; waits until wr_en[SYS_ARR_COLS-1] of the final beat has issued, then → DONE.
- DONE: done=1 for exactly one cycle; busy=0; → IDLE.
  - start in DONE is ignored.
  - start is accepted the cycle after DONE.
- busy = 1 in RUN and DRAIN, 0 otherwise.
- start in RUN or DRAIN is ignored; cfg_* is not re-latched.
- Latency: final beat at t → done at t+SYS_ARR_COLS+1.
- Reset mid-job: outputs zero asynchronously; pending skewed writes are discarded; no done is issued.

Test Plan:
- Defaults, cfg all 0, start, 16 consecutive beats from t0 → wr_en[0] addrs 0..15 at t0+1..t0+16; column 15 gets addr 0 at t0+16 and addr 15 at t0+31; accum_en all 0; done only at t0+32.
- cfg_m_last=1, cfg_n_last=1, cfg_k_last=0, 64 beats:
  - column-0 addrs 0..15, 16..31, 128..143, 144..159 in order.
  - done 17 cycles after the 64th beat.
- cfg_k_last=1, other cfg 0, 32 beats:
  - beats 0–15: addrs 0..15, accum_en=0.
  - beats 16–31: addrs 0..15, accum_en=1 on every column.
- Stall: sys_out_valid pattern 1,0,0,1 → column 0 writes addr 0, two idle cycles, then addr 1; column 5 shows the same pattern delayed 5 cycles.
- start pulsed during RUN with different cfg → ignored; addresses follow the original cfg; exactly one done.
- reset asserted mid-RUN after 7 beats → all outputs 0 immediately; state IDLE; no done; a new start then produces addrs from 0.
